// File: rtl/pingpong_buffer_scheduler.sv
// ---------------------------------------------------------------------------
// pingpong_buffer_scheduler
//
// Purpose:
//   Schedules two external RAM banks (ram1, ram2) as a ping-pong frame buffer.
//   The producer fills one bank while the consumer drains the other. Bank
//   ownership only changes on whole-frame boundaries, so the consumer never
//   reads a partially written frame.
//
// Ports:
//   i_clk, i_reset        clock and asynchronous active-high reset
//   i_in_valid/i_in_data  producer sample; o_in_ready = sample accepted
//   i_out_ready           consumer asks for the next sample
//   o_out_valid/o_out_data  one-cycle strobe carrying the sample read back
//   o_ramN_we/waddr/wdata   write port of bank N (N = 1, 2)
//   o_ramN_re/raddr         read port of bank N
//   i_ramN_rdata            registered read data of bank N (1-cycle latency)
//   o_wr_bank / o_rd_bank   bank being filled / bank being drained (0 = ram1)
//   o_frame_done            one-cycle pulse after a bank finishes draining
//   o_frame_count           drained frames, modulo 256
// ---------------------------------------------------------------------------
module pingpong_buffer_scheduler #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_ram1_we,
  output logic [ADDR_W-1:0] o_ram1_waddr,
  output logic [DATA_W-1:0] o_ram1_wdata,
  output logic              o_ram1_re,
  output logic [ADDR_W-1:0] o_ram1_raddr,
  input  logic [DATA_W-1:0] i_ram1_rdata,
  output logic              o_ram2_we,
  output logic [ADDR_W-1:0] o_ram2_waddr,
  output logic [DATA_W-1:0] o_ram2_wdata,
  output logic              o_ram2_re,
  output logic [ADDR_W-1:0] o_ram2_raddr,
  input  logic [DATA_W-1:0] i_ram2_rdata,
  output logic              o_wr_bank,
  output logic              o_rd_bank,
  output logic              o_frame_done,
  output logic [7:0]        o_frame_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_rd_pending;
  logic              r_rd_src;
  logic [DATA_W-1:0] r_out_data;
  logic              r_frame_done;
  logic [7:0]        r_frame_count;

  logic              w_accept;
  logic              w_issue;
  logic              w_wr_last;
  logic              w_rd_last;
  logic [1:0]        w_we;
  logic [1:0]        w_re;
  logic [1:0]        w_full_next;
  logic [DATA_W-1:0] w_rdata_sel;

  // Handshakes are held off while reset is asserted so no RAM enable can
  // fire during reset even if the neighbours keep their requests high.
  assign o_in_ready = !i_reset && !r_full[r_wr_bank];
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_issue    = !i_reset && i_out_ready && r_full[r_rd_bank];
  assign w_wr_last  = w_accept && (r_waddr == LAST_ADDR);
  assign w_rd_last  = w_issue && (r_raddr == LAST_ADDR);

  // Per-bank enables and full-flag update. The writer only touches a bank
  // that is not full and the reader only a bank that is full, so for any
  // given bank at most one of the two updates can apply in a cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign w_we[gi] = w_accept && (r_wr_bank == 1'(gi));
      assign w_re[gi] = w_issue  && (r_rd_bank == 1'(gi));
      assign w_full_next[gi] = (w_we[gi] && w_wr_last) ? 1'b1 :
                               (w_re[gi] && w_rd_last) ? 1'b0 : r_full[gi];
    end
  endgenerate

  assign o_ram1_we    = w_we[0];
  assign o_ram1_waddr = r_waddr;
  assign o_ram1_wdata = i_in_data;
  assign o_ram1_re    = w_re[0];
  assign o_ram1_raddr = r_raddr;
  assign o_ram2_we    = w_we[1];
  assign o_ram2_waddr = r_waddr;
  assign o_ram2_wdata = i_in_data;
  assign o_ram2_re    = w_re[1];
  assign o_ram2_raddr = r_raddr;

  // The RAM already registers its read data, so the sample is presented on
  // the cycle after issue straight from the issuing bank and captured into
  // r_out_data, which then holds it until the next strobe.
  assign w_rdata_sel = r_rd_src ? i_ram2_rdata : i_ram1_rdata;
  assign o_out_valid = r_rd_pending;
  assign o_out_data  = r_rd_pending ? w_rdata_sel : r_out_data;

  assign o_wr_bank     = r_wr_bank;
  assign o_rd_bank     = r_rd_bank;
  assign o_frame_done  = r_frame_done;
  assign o_frame_count = r_frame_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_full        <= 2'b00;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_waddr       <= '0;
      r_raddr       <= '0;
      r_rd_pending  <= 1'b0;
      r_rd_src      <= 1'b0;
      r_out_data    <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_full       <= w_full_next;
      r_rd_pending <= w_issue;
      r_frame_done <= w_rd_last;

      if (w_accept) begin
        if (w_wr_last) begin
          r_waddr   <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_waddr   <= r_waddr + ADDR_W'(1);
        end
      end

      if (w_issue) begin
        r_rd_src <= r_rd_bank;
        if (w_rd_last) begin
          r_raddr       <= '0;
          r_rd_bank     <= ~r_rd_bank;
          r_frame_count <= r_frame_count + 8'd1;
        end else begin
          r_raddr       <= r_raddr + ADDR_W'(1);
        end
      end

      if (r_rd_pending) begin
        r_out_data <= w_rdata_sel;
      end
    end
  end

  // A bank is never written and read in the same cycle.
  a_no_bank_collision: assert property (@(posedge i_clk) disable iff (i_reset)
    !(o_ram1_we && o_ram1_re) && !(o_ram2_we && o_ram2_re));

endmodule

// File: tb/tb_pingpong_buffer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pingpong_buffer_scheduler
//
// Drives directed and randomized producer/consumer traffic into the ping-pong
// scheduler with two behavioural RAM banks attached. The reference model
// only counts accepted writes (W) and issued reads (R): frames written are
// W/32, frames drained are R/32, and every port expectation follows from
// those counts. Read-back samples are pushed into a scoreboard queue at
// issue time and popped by an independent monitor on each o_out_valid.
// ---------------------------------------------------------------------------
module tb_pingpong_buffer_scheduler;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEP = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          ram1_we, ram1_re, ram2_we, ram2_re;
  logic [AW-1:0] ram1_waddr, ram1_raddr, ram2_waddr, ram2_raddr;
  logic [DW-1:0] ram1_wdata, ram2_wdata;
  logic [DW-1:0] ram1_rdata, ram2_rdata;
  logic          wr_bank, rd_bank, frame_done;
  logic [7:0]    frame_count;

  always #5 clk = ~clk;

  pingpong_buffer_scheduler #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .i_out_ready  (out_ready),
    .o_out_valid  (out_valid),
    .o_out_data   (out_data),
    .o_ram1_we    (ram1_we),
    .o_ram1_waddr (ram1_waddr),
    .o_ram1_wdata (ram1_wdata),
    .o_ram1_re    (ram1_re),
    .o_ram1_raddr (ram1_raddr),
    .i_ram1_rdata (ram1_rdata),
    .o_ram2_we    (ram2_we),
    .o_ram2_waddr (ram2_waddr),
    .o_ram2_wdata (ram2_wdata),
    .o_ram2_re    (ram2_re),
    .o_ram2_raddr (ram2_raddr),
    .i_ram2_rdata (ram2_rdata),
    .o_wr_bank    (wr_bank),
    .o_rd_bank    (rd_bank),
    .o_frame_done (frame_done),
    .o_frame_count(frame_count)
  );

  // Behavioural RAM banks: synchronous write, registered read, never cleared.
  logic [DW-1:0] mem1 [DEP];
  logic [DW-1:0] mem2 [DEP];

  always @(posedge clk) begin
    if (ram1_we) mem1[ram1_waddr] <= ram1_wdata;
    if (ram1_re) ram1_rdata <= mem1[ram1_raddr];
    if (ram2_we) mem2[ram2_waddr] <= ram2_wdata;
    if (ram2_re) ram2_rdata <= mem2[ram2_raddr];
  end

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          W = 0;
  int          R = 0;
  bit          prev_issue = 1'b0;
  bit          prev_done = 1'b0;
  logic [DW-1:0] wr_hist[$];
  logic [DW-1:0] exp_q[$];
  int          done_seen = 0;
  bit          wrap_seen = 1'b0;
  logic [DW-1:0] last_out = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expected sample per out_valid strobe and
  // checks that out_data holds between strobes.
  always @(negedge clk) begin
    if (reset) begin
      last_out = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_valid_unexpected: got data %0d expected no strobe at t=%0t",
                 out_data, $time);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
      last_out = out_data;
    end else begin
      chk("out_data_hold", out_data, last_out);
    end
  end

  // One clock cycle of stimulus. Entered #1 after a rising edge; inputs are
  // applied, outputs are checked on the falling edge, then the model advances.
  task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy);
    int fw, fr;
    bit exp_rdy, acc, iss;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    fw = W / DEP;
    fr = R / DEP;
    exp_rdy = (fw - fr) < 2;
    acc = iv && exp_rdy;
    iss = ordy && ((fw - fr) >= 1);

    chk("in_ready", in_ready, exp_rdy);
    chk("ram1_we", ram1_we, acc && (fw % 2 == 0));
    chk("ram2_we", ram2_we, acc && (fw % 2 == 1));
    if (acc) begin
      chk("waddr", (fw % 2 == 1) ? ram2_waddr : ram1_waddr, W % DEP);
      chk("wdata", (fw % 2 == 1) ? ram2_wdata : ram1_wdata, d);
    end
    chk("ram1_re", ram1_re, iss && (fr % 2 == 0));
    chk("ram2_re", ram2_re, iss && (fr % 2 == 1));
    if (iss) begin
      chk("raddr", (fr % 2 == 1) ? ram2_raddr : ram1_raddr, R % DEP);
    end
    chk("bank_collision", (ram1_we && ram1_re) || (ram2_we && ram2_re), 0);
    chk("wr_bank", wr_bank, fw % 2);
    chk("rd_bank", rd_bank, fr % 2);
    chk("frame_count", frame_count, fr % 256);
    chk("frame_done", frame_done, prev_done);
    chk("out_valid", out_valid, prev_issue);

    if (frame_done) begin
      done_seen++;
      if (frame_count == 8'd0) wrap_seen = 1'b1;
      $display("frame done #%0d frame_count=%0d t=%0t", done_seen, frame_count, $time);
    end

    prev_done = 1'b0;
    if (acc) begin
      wr_hist.push_back(d);
      W++;
    end
    if (iss) begin
      exp_q.push_back(wr_hist[R]);
      prev_done = (R % DEP == DEP - 1);
      R++;
    end
    prev_issue = iss;
    @(posedge clk);
    #1;
  endtask

  // Reset with both handshakes requesting, check the reset state, restart model.
  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_ram1_we", ram1_we, 0);
    chk("rst_ram2_we", ram2_we, 0);
    chk("rst_ram1_re", ram1_re, 0);
    chk("rst_ram2_re", ram2_re, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 0);
    W = 0;
    R = 0;
    wr_hist.delete();
    exp_q.delete();
    prev_issue = 1'b0;
    prev_done  = 1'b0;
    done_seen  = 0;
    wrap_seen  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Partial fill to address 17, then reset mid-frame.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);
    do_reset();

    // Fill both banks with 0..63, then confirm the producer is held off.
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0);

    // Drain both frames with out_ready high.
    for (int i = 0; i < 70; i++) step(1'b0, 8'h00, 1'b1);

    // Refill, then drain with out_ready alternating.
    for (int i = 0; i < 64; i++) step(1'b1, 8'(64 + i), 1'b0);
    for (int i = 0; i < 140; i++) step(1'b0, 8'h00, (i % 2) == 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);

    // Continuous streaming until frame_count has wrapped.
    n = 0;
    while (R < 258 * DEP && n < 12000) begin
      step(1'b1, 8'($urandom), 1'b1);
      n++;
    end
    chk("frame_count_wrap_seen", wrap_seen, 1);

    // Idle so every issued read comes back, then the scoreboard must be empty.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pingpong_buffer_scheduler.md
Name: pingpong_buffer_scheduler

Overview:
Sequences two identical single-port-per-side RAM banks (ram1, ram2) as a ping-pong frame buffer between a sample producer and a drawing consumer. While the producer fills one bank, the consumer drains the other. Bank ownership swaps only on whole-frame boundaries, so the consumer never sees a partially written frame. The block sits between the data-generation stage and the drawing stage. It owns all RAM enables, addresses and write data.

Parameters:
ADDR_W, 5, bank address width.
DATA_W, 8, sample width.
DEPTH, 32, samples per frame (≤ 2**ADDR_W); last address is DEPTH-1.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  producer sample valid.
in_data  in  DATA_W  producer sample.
in_ready  out  1  scheduler can accept a sample this cycle.
out_ready  in  1  consumer requests the next sample.
out_valid  out  1  out_data is valid this cycle (single-cycle strobe).
out_data  out  DATA_W  sample read from the drain bank.
ram1_we  out  1  bank-1 write enable.
ram1_waddr  out  ADDR_W  bank-1 write address.
ram1_wdata  out  DATA_W  bank-1 write data.
ram1_re  out  1  bank-1 read enable.
ram1_raddr  out  ADDR_W  bank-1 read address.
ram1_rdata  in  DATA_W  bank-1 read data, registered, 1-cycle latency.
ram2_we, ram2_waddr, ram2_wdata, ram2_re, ram2_raddr, ram2_rdata: same as bank 1, for bank 2.
wr_bank  out  1  bank currently being filled (0 = ram1).
rd_bank  out  1  bank currently drained or next to drain.
frame_done  out  1  one-cycle pulse when a bank finishes draining.
frame_count  out  8  completed drained frames, wraps 255→0.

Behaviour:
- State: full[1:0], wr_bank, rd_bank, waddr, raddr, rd_pending (issue tracking for out_valid), rd_src (bank of the pending read).
- Reset, asynchronous:
  - full=0, wr_bank=0, rd_bank=0, waddr=0, raddr=0, rd_pending=0, frame_count=0.
  - All RAM enables 0, out_valid=0, frame_done=0, out_data=0.
  - RAM contents are not cleared.
  - Reset mid-frame abandons both banks; the next frame starts at ram1, address 0.
- Write side:
  - in_ready = !full[wr_bank], combinational.
  - Accept = in_valid & in_ready. On accept, drive the wr_bank RAM's we=1, waddr=waddr, wdata=in_data in the same cycle. The other bank's we=0.
  - After accept, waddr increments. On accept at waddr=DEPTH-1: waddr←0, full[wr_bank]←1, wr_bank toggles.
  - in_valid while in_ready=0 is ignored; the producer holds the sample.
- Read side:
  - Issue = out_ready & full[rd_bank]. On issue, drive the rd_bank RAM's re=1, raddr=raddr. The other bank's re=0.
  - After issue, raddr increments. On issue at raddr=DEPTH-1: raddr←0, full[rd_bank]←0, rd_bank toggles, frame_done pulses next cycle, frame_count increments.
  - The cycle after an issue: out_valid=1 and out_data = rdata of the issuing bank, registered into out_data.
  - out_valid is an unconditional strobe: no backpressure after issue. out_ready gates issue only.
  - out_data holds its last value when out_valid=0.
- Throughput: one write and one read per cycle sustained, in different banks.
- First sample out: the earliest issue is in the cycle after the first bank becomes full. Latency from the last write of frame 0 to its first out_valid is 2 cycles, with out_ready held high.
- Simultaneous events:
  - Write completing bank A and read completing bank B in the same cycle: both full updates apply, both pointers toggle.
  - Read completing bank X while the writer waits on X (full[X]=1): in_ready rises the following cycle, never the same cycle.
  - Write and read never target the same bank in the same cycle. An assertion checks ram1_we&ram1_re and ram2_we&ram2_re are never 1.
- Both banks full: in_ready=0 until the drain of rd_bank completes.
- Both banks empty: no issue regardless of out_ready; out_valid stays 0.
- Widths: waddr/raddr are ADDR_W bits; frame_count rolls over modulo 256 silently.

Test Plan:
1. Reset asserted mid-fill (waddr=17) → next cycle waddr=0, wr_bank=0, in_ready=1, all enables 0, frame_count=0.
2. in_valid=1 continuously with data 0..31, out_ready=0 → ram1 written at addresses 0..31, then wr_bank=1. Next data 32..63 go to ram2; then in_ready=0.
3. With both banks filled as in test 2, raise out_ready for 64 cycles → out_valid strobes carry 0..63 in order, each 1 cycle after its issue. frame_done pulses twice; frame_count=2; in_ready rises after the first frame drains.
4. Continuous in_valid=1 and out_ready=1 → after the first fill, sustained 1 write + 1 read per cycle on opposite banks. The we/re same-bank assertion never fires.
5. out_ready toggled 1-0-1-0 during a drain → issues only in out_ready cycles, raddr advances by one per issue, no duplicate or skipped samples.
6. Run 256 frames → frame_count wraps to 0 on the 256th frame_done.
